qpsk_mapper: RTL and testbench

- Serial-bit QPSK symbol mapper in the transmit baseband chain, between the bit source (scrambler/framer) and the pulse-shaping filter.
- Accepts one bit per valid cycle and pairs consecutive bits.
- Emits one Gray-coded I/Q symbol per completed pair as a packed 32-bit word with a one-cycle valid strobe.

---
 rtl/qpsk_mapper_if.sv | 31 +++
 rtl/qpsk_mapper.sv | 78 +++++++
 tb/tb_qpsk_mapper.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/qpsk_mapper_if.sv
`default_nettype none
// ============================================================================
//  Module   : qpsk_mapper_if
//  Brief    : Serial-bit input / packed I-Q symbol output bundle for the
//             QPSK mapper. The master drives bits and observes symbols;
//             the slave (the mapper) does the opposite.
//  Revision : 1.0  initial release
// ============================================================================
interface qpsk_mapper_if #(
  parameter int OUT_WIDTH = 32
);
  logic                 i_data;
  logic                 i_valid;
  logic [OUT_WIDTH-1:0] o_data;
  logic                 o_valid;

  modport master (
    output i_data,
    output i_valid,
    input  o_data,
    input  o_valid
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_data,
    output o_valid
  );
endinterface
`default_nettype wire

// File: rtl/qpsk_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : qpsk_mapper
//  Brief    : Pairs consecutive valid serial bits and emits one Gray-coded
//             QPSK symbol {I, Q} per completed pair with a one-cycle strobe.
//             Bit 0 maps to +AMPLITUDE, bit 1 to -AMPLITUDE on each axis.
//  Revision : 1.0  initial release
// ============================================================================
module qpsk_mapper #(
  parameter int OUT_WIDTH = 32,
  parameter int AMPLITUDE = 23170
) (
  input  logic             i_clk,
  input  logic             i_reset,   // asynchronous, active low
  qpsk_mapper_if.slave     bus
);

  localparam int HALF = OUT_WIDTH / 2;
  localparam logic [HALF-1:0] C_POS = HALF'(AMPLITUDE);
  localparam logic [HALF-1:0] C_NEG = HALF'(-AMPLITUDE);

  typedef enum logic [0:0] {
    ST_FIRST  = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 first_bit_q, first_bit_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;

  // Gray mapping of one bit onto one axis.
  function automatic logic [HALF-1:0] axis_map(input logic b);
    return b ? C_NEG : C_POS;
  endfunction

  // Next-state: only valid cycles advance the pair; the strobe defaults low.
  always_comb begin
    state_d     = state_q;
    first_bit_d = first_bit_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    if (bus.i_valid) begin
      case (state_q)
        ST_FIRST: begin
          first_bit_d = bus.i_data;
          state_d     = ST_SECOND;
        end
        ST_SECOND: begin
          data_d  = {axis_map(first_bit_q), axis_map(bus.i_data)};
          valid_d = 1'b1;
          state_d = ST_FIRST;
        end
        default: state_d = ST_FIRST;
      endcase
    end
  end

  // State, stored half pair and output registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_FIRST;
      first_bit_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_bit_q <= first_bit_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_mapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qpsk_mapper
//  Brief    : Self-checking bench for qpsk_mapper. A bit-pairing model
//             computes the expected symbol and strobe for every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qpsk_mapper;

  localparam int OUT_WIDTH = 32;
  localparam int AMPLITUDE = 23170;
  localparam int HALF      = OUT_WIDTH / 2;

  logic clk;
  logic rst_n;

  qpsk_mapper_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

  qpsk_mapper #(
    .OUT_WIDTH (OUT_WIDTH),
    .AMPLITUDE (AMPLITUDE)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: a list of pending bits and the expected outputs.
  bit                   pend_q[$];
  logic [OUT_WIDTH-1:0] exp_data;
  logic                 exp_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Symbol value from two bits using signed arithmetic on each axis.
  function automatic logic [OUT_WIDTH-1:0] symbol(input bit b_i, input bit b_q);
    int iv;
    int qv;
    iv = b_i ? -AMPLITUDE : AMPLITUDE;
    qv = b_q ? -AMPLITUDE : AMPLITUDE;
    return {HALF'(iv), HALF'(qv)};
  endfunction

  // Present one input for one cycle, advance the model, then check outputs.
  task automatic step(input bit v, input bit d, input string tag);
    @(negedge clk);
    bus.i_valid = v;
    bus.i_data  = d;
    @(posedge clk);
    exp_valid = 1'b0;
    if (v) begin
      pend_q.push_back(d);
      if (pend_q.size() == 2) begin
        exp_data  = symbol(pend_q[0], pend_q[1]);
        exp_valid = 1'b1;
        pend_q.delete();
      end
    end
    #1;
    check({tag, "_valid"}, 64'(bus.o_valid), 64'(exp_valid));
    check({tag, "_data"},  64'(bus.o_data),  64'(exp_data));
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_async_valid"}, 64'(bus.o_valid), 64'd0);
    check({tag, "_async_data"},  64'(bus.o_data),  64'd0);
    pend_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_data  = 1'b0;
    exp_data    = '0;
    exp_valid   = 1'b0;

    // Reset and quiet idle
    do_reset("rst");
    repeat (3) step(1'b0, 1'b0, "idle");

    // 0,0 back to back
    step(1'b1, 1'b0, "p00a");
    step(1'b1, 1'b0, "p00b");
    check("p00_const", 64'(bus.o_data), 64'h5A825A82);

    // 0, gap of 2, then 1
    step(1'b1, 1'b0, "gap_a");
    step(1'b0, 1'b1, "gap_1");
    step(1'b0, 1'b1, "gap_2");
    step(1'b1, 1'b1, "gap_b");
    check("p01_const", 64'(bus.o_data), 64'h5A82A57E);

    // 1,0 then 1,1 back to back
    step(1'b1, 1'b1, "p10a");
    step(1'b1, 1'b0, "p10b");
    check("p10_const", 64'(bus.o_data), 64'hA57E5A82);
    step(1'b1, 1'b1, "p11a");
    check("p11_between", 64'(bus.o_valid), 64'd0);
    step(1'b1, 1'b1, "p11b");
    check("p11_const", 64'(bus.o_data), 64'hA57EA57E);

    // Idle hold after a symbol
    repeat (10) step(1'b0, 1'b0, "hold");
    check("hold_const", 64'(bus.o_data), 64'hA57EA57E);

    // Half pair discarded by reset
    step(1'b1, 1'b1, "half");
    do_reset("midrst");
    step(1'b1, 1'b0, "post_a");
    step(1'b1, 1'b0, "post_b");
    check("post_const", 64'(bus.o_data), 64'h5A825A82);

    // Randomised traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
